// File: rtl/comp2bit_arbiter.sv
// comp2bit_arbiter: one shared 2-bit magnitude comparator serving NREQ requesters.
// A round-robin grant captures one operand pair. The pair is compared in a
// registered stage, and the one-hot result is held with its requester id until
// the consumer accepts it.
module comp2bit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2,
  parameter int CNTW  = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2:0]            rsp_cmp,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       cmp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [IDW-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;
  logic [IDW-1:0]    id_q,        id_d;
  logic [IDW-1:0]    rsp_id_q,    rsp_id_d;
  logic [2:0]        rsp_cmp_q,   rsp_cmp_d;
  logic [CNTW-1:0]   cmp_count_q, cmp_count_d;

  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  int                idx;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Next-state and datapath sequencing: IDLE -> CMP -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_cmp_d   = rsp_cmp_q;
    cmp_count_d = cmp_count_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          id_d    = grant_idx;
          state_d = CMP;
        end
      end
      CMP: begin
        if (a_q > b_q)       rsp_cmp_d = 3'b100;
        else if (a_q == b_q) rsp_cmp_d = 3'b010;
        else                 rsp_cmp_d = 3'b001;
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          cmp_count_d = cmp_count_q + 1'b1;
          rr_ptr_d    = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are plain flops and are cleared like the rest, so the block leaves reset in a known state.
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_cmp_q   <= 3'b000;
      cmp_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value of the others.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cmp_q   <= rsp_cmp_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_cmp   = rsp_cmp_q;
  assign cmp_count = cmp_count_q;

endmodule

// File: tb/tb_comp2bit_arbiter.sv
// tb_comp2bit_arbiter: directed and random stimulus against a transaction-level
// reference model (pending request, age in cycles, round-robin pointer, count).
module tb_comp2bit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 2;
  localparam int CNTW = 2;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2:0]          rsp_cmp;
  logic                rsp_ready;
  logic                busy;
  logic [CNTW-1:0]     cmp_count;

  comp2bit_arbiter #(.NREQ(NREQ), .WIDTH(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cmp(rsp_cmp),
    .rsp_ready(rsp_ready), .busy(busy), .cmp_count(cmp_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit       m_busy;
  int       m_age;
  int       m_id;
  int       m_ptr;
  int       m_count;
  logic [2:0] m_cmp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [2:0] ref_cmp(input int a, input int b);
    if (a > b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_id = 0; m_ptr = 0; m_count = 0; m_cmp = 3'b000;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                      input logic [NREQ*W-1:0] b, input logic rr);
    int g;
    logic [NREQ-1:0] exp_ready;
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    g = m_busy ? -1 : pick(v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_cmp", 32'(rsp_cmp), 32'(m_cmp));
    end
    check("cmp_count", 32'(cmp_count), 32'(m_count % (1 << CNTW)));
    @(posedge clk);
    if (g >= 0) begin
      m_busy = 1; m_age = 1; m_id = g;
      m_cmp = ref_cmp(int'((a >> (g*W)) & 3), int'((b >> (g*W)) & 3));
    end else if (m_busy) begin
      if (m_age >= 2 && rr) begin
        m_busy = 0; m_count++; m_ptr = (m_id + 1) % NREQ;
      end else begin
        m_age = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [NREQ*W-1:0] ra, rb;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_cmp", 32'(rsp_cmp), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on requester 2: a=10, b=01 -> a>b.
    step(4'b0100, 8'b00_10_00_00, 8'b00_01_00_00, 1'b1);
    idle_steps(3);
    check("single_count", 32'(cmp_count), 1);

    // Exhaustive compare on requester 0.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        step(4'b0001, 8'(a), 8'(b), 1'b1);
        step('0, '0, '0, 1'b1);
        check("exh_cmp", 32'(rsp_cmp), 32'(ref_cmp(a, b)));
        step('0, '0, '0, 1'b1);
      end
    end

    // Round robin with everyone valid.
    for (int i = 0; i < 15; i++) step(4'hF, 8'($urandom), 8'($urandom), 1'b1);
    idle_steps(3);

    // Backpressure: hold RESP for five cycles with everyone requesting.
    step(4'b0010, 8'b00_00_11_00, 8'b00_00_01_00, 1'b1);
    step(4'hF, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'hF, 8'($urandom), 8'($urandom), 1'b0);
    step('0, '0, '0, 1'b1);
    idle_steps(2);

    // Reset in the middle of RESP, then expect grant to requester 0.
    step(4'b0100, 8'b00_01_00_00, 8'b00_10_00_00, 1'b1);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    check("arst_count", 32'(cmp_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF;
    #1;
    check("first_grant", 32'(req_ready), 1);
    step(4'hF, 8'($urandom), 8'($urandom), 1'b1);
    idle_steps(3);

    // Random traffic, including counter wraps.
    for (int i = 0; i < 600; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(4'($urandom), ra, rb, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
